// File: rtl/sub_bytes_if.sv
// Handshake bundle between the SubBytes stage and its neighbours.
// The master drives the input block and the output backpressure; the slave is the stage itself.
interface sub_bytes_if;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [0:127] state_out;
    logic         busy;

    modport master (
        output in_valid,
        output state_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  state_out,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  state_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output state_out,
        output busy
    );
endinterface

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: LANES bytes per clock through LANES shared S-box lookups.
// State layout is [0:127], byte k at bits [8k+:8].
module sub_bytes_iter #(
    parameter int unsigned LANES = 4
) (
    input  logic       clk,
    input  logic       rst,
    sub_bytes_if.slave bus
);
    localparam int unsigned NumCyc = 16 / LANES;
    localparam int unsigned CntW   = (NumCyc > 1) ? $clog2(NumCyc) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end

    // FIPS-197 forward S-box; entry x sits at bits [8x+:8].
    localparam logic [0:2047] SboxTable = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SboxTable[{x, 3'b000} +: 8];
    endfunction

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t        fsm_q;
    logic [0:127]  work_q;
    logic [CntW-1:0] cnt_q;
    logic [0:127]  work_sub;

    // Substitute the LANES bytes addressed by the current count; everything else holds.
    always_comb begin
        logic [3:0] idx;
        idx      = '0;
        work_sub = work_q;
        for (int unsigned j = 0; j < LANES; j++) begin
            idx = 4'((32'(cnt_q) * LANES) + j);
            work_sub[{idx, 3'b000} +: 8] = sbox(work_q[{idx, 3'b000} +: 8]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q  <= StIdle;
            cnt_q  <= '0;
            work_q <= '0;
        end else begin
            unique case (fsm_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        work_q <= bus.state_in;
                        cnt_q  <= '0;
                        fsm_q  <= StRun;
                    end
                end
                StRun: begin
                    work_q <= work_sub;
                    if (cnt_q == CntW'(NumCyc - 1)) begin
                        cnt_q <= '0;
                        fsm_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        fsm_q <= StIdle;
                    end
                end
                default: fsm_q <= StIdle;
            endcase
        end
    end

    // rst gating keeps in_ready low for the whole reset pulse, not just after the first edge.
    assign bus.in_ready  = (fsm_q == StIdle) && !rst;
    assign bus.out_valid = (fsm_q == StDone);
    assign bus.busy      = (fsm_q == StRun);
    assign bus.state_out = work_q;
endmodule

// File: tb/tb_sub_bytes_iter.sv
// Bench for sub_bytes_iter: scoreboard on a LANES=4 instance plus a latency/result sweep
// over the other legal LANES values, all against a GF(2^8) reference S-box.
module tb_sub_bytes_iter;
    localparam logic [0:127] AppbIn  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [0:127] AppbOut = 128'hd42711aee0bf98f1b8b45de51e415230;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sw_rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   sweeps_done = 0;
    logic rnd_bp = 1'b0;
    logic [0:127] exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sub_bytes_if dut_if ();
    sub_bytes_iter #(.LANES(4)) dut (.clk(clk), .rst(rst), .bus(dut_if));

    // Reference S-box from its definition: multiplicative inverse in GF(2^8), then affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] ref_sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        logic [7:0] s;
        for (int y = 1; y < 256; y++)
            if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [0:127] ref_state(input logic [0:127] v);
        logic [0:127] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = ref_sbox(v[8*k +: 8]);
        return r;
    endfunction

    function automatic logic [0:127] rand_vec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_vec(input string name, input logic [0:127] got, input logic [0:127] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    task automatic check_int(input string name, input int got, input int req);
        total++;
        if (got != req) begin
            bad++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    // Monitor: every completed output handshake pops one expected block.
    always @(negedge clk) begin
        if (!rst && dut_if.out_valid && dut_if.out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out got=%h required=none", dut_if.state_out);
            end else begin
                check_vec("sb_out", dut_if.state_out, exp_q.pop_front());
            end
        end
    end

    // Present a block, queue its expected result, return #1 after the accepting edge.
    task automatic run_block(input logic [0:127] v, input logic [0:127] req, input bit hold,
                             output int acc_cyc);
        bit acc = 1'b0;
        int n = 0;
        dut_if.in_valid = 1'b1;
        dut_if.state_in = v;
        exp_q.push_back(req);
        acc_cyc = -1;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = dut_if.in_ready;
            acc_cyc = cyc;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check_int("accept_timeout", n, 0);
        if (!hold) dut_if.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) check_int("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        int busy_cnt;
        int acc [3];
        logic [0:127] v;
        dut_if.in_valid  = 1'b0;
        dut_if.state_in  = '0;
        dut_if.out_ready = 1'b0;

        #2;
        check_int("rst_in_ready", int'(dut_if.in_ready), 0);
        check_int("rst_out_valid", int'(dut_if.out_valid), 0);
        check_int("rst_busy", int'(dut_if.busy), 0);
        check_vec("rst_state_out", dut_if.state_out, '0);
        #10 rst = 1'b0;
        #1 check_int("post_rst_in_ready", int'(dut_if.in_ready), 1);
        @(posedge clk);
        #1;

        // App. B vector with latency and busy-width checks.
        dut_if.out_ready = 1'b1;
        run_block(AppbIn, AppbOut, 1'b0, acc[0]);
        n = 0;
        busy_cnt = 0;
        while (!dut_if.out_valid && n < 40) begin
            busy_cnt += int'(dut_if.busy);
            @(posedge clk);
            #1;
            n++;
        end
        check_int("appb_latency_edges", n + 1, 5);
        check_int("appb_busy_cycles", busy_cnt, 4);
        @(posedge clk);
        #1;
        check_int("appb_valid_one_cycle", int'(dut_if.out_valid), 0);
        check_int("appb_in_ready_after", int'(dut_if.in_ready), 1);

        // Backpressure in DONE, with input traffic that must be ignored.
        dut_if.out_ready = 1'b0;
        run_block(AppbIn, AppbOut, 1'b0, acc[0]);
        n = 0;
        while (!dut_if.out_valid && n < 40) begin
            dut_if.in_valid = ~dut_if.in_valid;
            dut_if.state_in = n[0] ? {16{8'h53}} : rand_vec();
            @(posedge clk);
            #1;
            n++;
        end
        check_int("bp_reached_done", int'(dut_if.out_valid), 1);
        for (int i = 0; i < 10; i++) begin
            dut_if.in_valid = ~dut_if.in_valid;
            dut_if.state_in = {16{8'h53}};
            @(posedge clk);
            #1;
            check_int("bp_out_valid", int'(dut_if.out_valid), 1);
            check_vec("bp_state_out", dut_if.state_out, AppbOut);
            check_int("bp_in_ready", int'(dut_if.in_ready), 0);
        end
        dut_if.in_valid  = 1'b0;
        dut_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_int("bp_release_valid", int'(dut_if.out_valid), 0);
        check_int("bp_release_ready", int'(dut_if.in_ready), 1);
        run_block({16{8'h53}}, {16{8'hed}}, 1'b0, acc[0]);
        run_block({16{8'h00}}, {16{8'h63}}, 1'b0, acc[0]);
        run_block({16{8'hff}}, {16{8'h16}}, 1'b0, acc[0]);
        drain();

        // Asynchronous reset mid-RUN at cnt=2.
        run_block(AppbIn, AppbOut, 1'b0, acc[0]);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_int("mid_rst_out_valid", int'(dut_if.out_valid), 0);
        check_int("mid_rst_busy", int'(dut_if.busy), 0);
        check_int("mid_rst_in_ready", int'(dut_if.in_ready), 0);
        void'(exp_q.pop_back());
        @(posedge clk);
        #3 rst = 1'b0;
        #1 check_int("mid_rst_release_ready", int'(dut_if.in_ready), 1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check_int("mid_rst_no_stale", int'(dut_if.out_valid), 0);
        end
        run_block(AppbIn, AppbOut, 1'b0, acc[0]);
        drain();

        // Back-to-back with in_valid held high.
        for (int i = 0; i < 3; i++) begin
            v = rand_vec();
            run_block(v, ref_state(v), 1'b1, acc[i]);
        end
        dut_if.in_valid = 1'b0;
        check_int("b2b_spacing_0", acc[1] - acc[0], 6);
        check_int("b2b_spacing_1", acc[2] - acc[1], 6);
        drain();

        // Random blocks under random output backpressure.
        rnd_bp = 1'b1;
        fork
            begin
                while (rnd_bp) begin
                    @(posedge clk);
                    #1;
                    if (rnd_bp) dut_if.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        for (int i = 0; i < 12; i++) begin
            n = int'($urandom_range(0, 3));
            repeat (n) begin
                @(posedge clk);
                #1;
            end
            v = rand_vec();
            run_block(v, ref_state(v), 1'b0, acc[0]);
        end
        rnd_bp = 1'b0;
        @(posedge clk);
        #2 dut_if.out_ready = 1'b1;
        drain();

        n = 0;
        while (sweeps_done < 4 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        check_int("sweeps_complete", sweeps_done, 4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial #12 sw_rst = 1'b0;

    for (genvar g = 0; g < 4; g++) begin : g_sweep
        localparam int unsigned L = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
        sub_bytes_if sw_if ();
        sub_bytes_iter #(.LANES(L)) sw_dut (.clk(clk), .rst(sw_rst), .bus(sw_if));

        initial begin : sweep
            int n;
            logic [0:127] vin;
            logic [0:127] vreq;
            sw_if.in_valid  = 1'b0;
            sw_if.state_in  = '0;
            sw_if.out_ready = 1'b1;
            wait (!sw_rst);
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                case (i)
                    0:       begin vin = AppbIn;         vreq = AppbOut;        end
                    1:       begin vin = {16{8'h00}};    vreq = {16{8'h63}};    end
                    default: begin vin = {16{8'hff}};    vreq = {16{8'h16}};    end
                endcase
                check_int($sformatf("sweep%0d_in_ready", L), int'(sw_if.in_ready), 1);
                sw_if.in_valid = 1'b1;
                sw_if.state_in = vin;
                @(posedge clk);
                #1;
                sw_if.in_valid = 1'b0;
                n = 0;
                while (!sw_if.out_valid && n < 40) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                check_int($sformatf("sweep%0d_latency", L), n + 1, int'(16 / L) + 1);
                check_vec($sformatf("sweep%0d_result", L), sw_if.state_out, vreq);
                @(posedge clk);
                #1;
            end
            sweeps_done++;
        end
    end
endmodule
